// File: rtl/instr_pkg.sv
// instr_pkg: opcode, funct and kind constants plus the request record shared by the encoder files
package instr_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SRAI = 3'b101;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] FUNCT7_SRA = 7'b0100000;
  localparam logic [2:0] K_ADDI = 3'd0;
  localparam logic [2:0] K_SRAI = 3'd1;
  localparam logic [2:0] K_LW = 3'd2;
  localparam logic [2:0] K_SW = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [2:0] kind;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [31:0] imm;
  } req_t;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer; immediate range flag only with INSTR_ENC_RANGE_CHECK_EN
import instr_pkg::*;
module instr_pack (
  input req_t req,
  output logic [31:0] instr,
  output logic illegal,
  output logic range_err
);
  logic [31:0] imm;
  assign imm = req.imm;
  assign illegal = req.kind > K_BEQ;
  always_comb begin
    instr = req.kind == K_ADDI ? {imm[11:0], req.rs1, F3_ADDI, req.rd, OP_IMM}
          : req.kind == K_SRAI ? {FUNCT7_SRA, imm[4:0], req.rs1, F3_SRAI, req.rd, OP_IMM}
          : req.kind == K_LW ? {imm[11:0], req.rs1, F3_LW, req.rd, LOAD}
          : req.kind == K_SW ? {imm[11:5], req.rs2, req.rs1, F3_SW, imm[4:0], STORE}
          : req.kind == K_BEQ ? {imm[12], imm[10:5], req.rs2, req.rs1, F3_BEQ, imm[4:1], imm[11], BRANCH}
          : NOP_INSTR;
  end
`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic fit12, fit5, fit13;
  assign fit12 = &imm[31:11] || ~|imm[31:11];
  assign fit5 = ~|imm[31:5];
  assign fit13 = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
  assign range_err = req.kind == K_SRAI ? !fit5
                   : req.kind == K_BEQ ? !fit13
                   : (req.kind == K_ADDI || req.kind == K_LW || req.kind == K_SW) ? !fit12
                   : 1'b0;
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:13];
  assign range_err = 1'b0;
`endif
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready RISC-V encoder with address tagging; range check via INSTR_ENC_RANGE_CHECK_EN
import instr_pkg::*;
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic clk_i,
  input logic rst_i,
  input logic in_valid_i,
  output logic in_ready_o,
  input logic [2:0] kind_i,
  input logic [4:0] rd_i,
  input logic [4:0] rs1_i,
  input logic [4:0] rs2_i,
  input logic [31:0] imm_i,
  output logic out_valid_o,
  input logic out_ready_i,
  output logic [31:0] instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic err_o
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  req_t s1_q, s1_d;
  logic [31:0] instr_q, instr_d, packed_instr;
  logic err_q, err_d, illegal, range_err, s1_err, s2_load;
  logic [ADDR_W-1:0] addr_q, addr_d;
  instr_pack u_pack (
    .req(s1_q),
    .instr(packed_instr),
    .illegal(illegal),
    .range_err(range_err)
  );
  assign s1_err = illegal || range_err;
  always_comb begin
    s2_load = !s2_valid_q || out_ready_i;
    in_ready_o = !s1_valid_q || s2_load;
    s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
    s1_d = (in_ready_o && in_valid_i) ? {kind_i, rd_i, rs1_i, rs2_i, imm_i} : s1_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    instr_d = (s2_load && s1_valid_q) ? packed_instr : instr_q;
    err_d = (s2_load && s1_valid_q) ? s1_err : err_q;
    addr_d = (s2_valid_q && out_ready_i) ? addr_q + ADDR_W'(4) : addr_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q <= '0;
      s2_valid_q <= 1'b0;
      instr_q <= '0;
      err_q <= 1'b0;
      addr_q <= BASE_ADDR;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q <= s1_d;
      s2_valid_q <= s2_valid_d;
      instr_q <= instr_d;
      err_q <= err_d;
      addr_q <= addr_d;
    end
  end
  assign out_valid_o = s2_valid_q;
  assign instr_o = instr_q;
  assign err_o = err_q;
  assign addr_o = addr_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a queue scoreboard checked by an independent output monitor
module tb_instr_encoder;
  logic clk_i = 1'b0;
  logic rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, err_o;
  logic [2:0] kind_i;
  logic [4:0] rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i, instr_o, addr_o;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] exp_addr;
  int checks = 0, failures = 0, cyc = 0, c0;
  logic rng;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .kind_i(kind_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .instr_o(instr_o),
    .addr_o(addr_o), .err_o(err_o)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", instr_o);
      end else begin
        e = q.pop_front();
        check("instr", instr_o, e.instr);
        check("addr", addr_o, e.addr);
        check("err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
  end
  task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    bit done = 0;
    in_valid_i = 1'b1;
    kind_i = k; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        q.push_back('{ei, exp_addr, ee});
        exp_addr += 32'd4;
        done = 1;
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    q.delete();
    exp_addr = 32'h0;
    @(negedge clk_i);
    check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1;
  endtask
  task automatic drain();
    for (int n = 0; n < 50 && q.size() > 0; n++) begin
      @(posedge clk_i); #1;
    end
    check("drain", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
`ifdef INSTR_ENC_RANGE_CHECK_EN
    rng = 1'b1;
`else
    rng = 1'b0;
`endif
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    kind_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    exp_addr = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    @(negedge clk_i);
    check("latency_c1", {31'b0, out_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("latency_c2", {31'b0, out_valid_o}, 32'd1);
    @(posedge clk_i); #1;
    drain();
    do_reset();
    c0 = cyc;
    send(3'd3, 5'd0, 5'd3, 5'd2, 32'd8, 32'h0021_A423, 1'b0);
    send(3'd4, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE20_8CE3, 1'b0);
    send(3'd1, 5'd5, 5'd6, 5'd0, 32'd3, 32'h4033_5293, 1'b0);
    check("burst_cycles", cyc - c0, 32'd3);
    send(3'd7, 5'd9, 5'd9, 5'd9, 32'h1234_5678, 32'h0000_0013, 1'b1);
    send(3'd2, 5'd3, 5'd2, 5'd0, -32'sd4, 32'hFFC1_2183, 1'b0);
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0000_0093, rng);
    send(3'd4, 5'd0, 5'd0, 5'd0, 32'd4096, 32'h8000_0063, rng);
    send(3'd1, 5'd0, 5'd0, 5'd0, 32'd32, 32'h4000_5013, rng);
    drain();
    do_reset();
    out_ready_i = 1'b0;
    send(3'd3, 5'd0, 5'd3, 5'd2, 32'd8, 32'h0021_A423, 1'b0);
    send(3'd4, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE20_8CE3, 1'b0);
    in_valid_i = 1'b1;
    kind_i = 3'd1; rd_i = 5'd5; rs1_i = 5'd6; rs2_i = 5'd0; imm_i = 32'd3;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      check("bp_in_ready", {31'b0, in_ready_o}, 32'd0);
      check("bp_valid", {31'b0, out_valid_o}, 32'd1);
      check("bp_instr", instr_o, 32'h0021_A423);
      check("bp_addr", addr_o, 32'h0);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    send(3'd1, 5'd5, 5'd6, 5'd0, 32'd3, 32'h4033_5293, 1'b0);
    drain();
    out_ready_i = 1'b0;
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(3'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    do_reset();
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    send(3'd0, 5'd2, 5'd1, 5'd0, 32'd5, 32'h0050_8113, 1'b0);
    drain();
    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined RISC-V instruction encoder. It packs register fields and a signed immediate into a 32-bit instruction word for the formats the core's immediate decoder consumes: ADDI, SRAI, LW, SW and BEQ.
- Used by the test/boot loader path to stream encoded instructions into instruction memory.
- Valid/ready on both sides. Every emitted word carries its write address.

Parameters:
- ADDR_W, 32, width of addr_o.
- BASE_ADDR, 0, address of the first emitted instruction after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  encoder can accept a request.
- kind_i  in  3  instruction kind: 0 ADDI, 1 SRAI, 2 LW, 3 SW, 4 BEQ; 5-7 illegal.
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- imm_i  in  32  signed immediate; byte offset for BEQ.
- out_valid_o  out  1  instr_o/addr_o/err_o valid.
- out_ready_i  in  1  consumer accepts the output.
- instr_o  out  32  encoded instruction.
- addr_o  out  ADDR_W  address for instr_o.
- err_o  out  1  error flag, qualified by out_valid_o.

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: out_valid_o=0, instr_o=0, err_o=0, addr_o=BASE_ADDR, both stage valids cleared. in_ready_o=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight requests without emitting them.
- Pipeline: two stages.
  - S1 registers the request and computes the error.
  - S2 holds the packed word and drives the outputs.
- Latency and throughput: 2 cycles from input handshake to out_valid_o when there is no backpressure. Throughput is 1 per cycle.
- Handshake and stall rules:
  - S2 loads when S2 is empty or out_ready_i=1.
  - S1 advances under the same condition.
  - in_ready_o = !s1_valid || !s2_valid || out_ready_i.
  - Outputs hold stable while out_valid_o=1 and out_ready_i=0.
  - Up to 2 requests are buffered. Order is preserved, and nothing is dropped or duplicated.
- Packing (rd/rs/imm in the standard positions):
  - ADDI: imm[11:0], rs1, funct3 000, rd, opcode 0010011.
  - SRAI: funct7 0100000, shamt=imm[4:0], rs1, funct3 101, rd, opcode 0010011.
  - LW: imm[11:0], rs1, funct3 010, rd, opcode 0000011.
  - SW: imm[11:5], rs2, rs1, funct3 010, imm[4:0], opcode 0100011.
  - BEQ: imm[12], imm[10:5], rs2, rs1, funct3 000, imm[4:1], imm[11], opcode 1100011. imm[0] is ignored.
  - Unused fields are taken only from the format; unused inputs are ignored.
  - Immediate bits above the field are truncated.
- Illegal kind (5-7): instr_o=32'h00000013 (NOP) and err_o=1.
- Address: addr_o advances by 4 on each output handshake (out_valid_o && out_ready_i) and wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: err_o=1 also when the immediate does not fit its field:
  - ADDI/LW/SW: outside -2048..2047.
  - SRAI: outside 0..31.
  - BEQ: outside -4096..4094, or odd.
  - The word is still packed from truncated bits.
- Undefined: err_o reflects only illegal kind; the range logic is absent.

Decomposition:
- Package instr_pkg holds:
  - opcode constants (OP_IMM, LOAD, STORE, BRANCH);
  - funct3 values and FUNCT7_SRA;
  - the kind encodings;
  - NOP_INSTR = 32'h00000013.
- Sub-module instr_pack (combinational): kind, regs and imm in; packed word and range flag out. Instantiated in S1→S2.

Test Plan:
- ADDI rd=1, rs1=0, imm=-1 after reset → instr_o=0xFFF00093, addr_o=0, err_o=0, out_valid_o 2 cycles after accept.
- Back-to-back burst, no backpressure:
  - SW rs1=3, rs2=2, imm=8 → 0x0021A423, addr 0.
  - BEQ rs1=1, rs2=2, imm=-8 → 0xFE208CE3, addr 4.
  - SRAI rd=5, rs1=6, imm=3 → 0x40335293, addr 8.
  - All three accepted on consecutive cycles.
- Backpressure: out_ready_i=0 for 4 cycles while 3 requests are offered.
  - in_ready_o drops after 2 are buffered.
  - Outputs stay stable while stalled.
  - On release, all 3 emerge in order with addresses 0, 4, 8.
- kind_i=7 → instr_o=0x00000013, err_o=1, and addr still increments.
- ADDI rd=1, imm=4096 → instr_o=0x00000093 in both builds; err_o=1 with INSTR_ENC_RANGE_CHECK_EN, err_o=0 without it.
- rst_i asserted for 1 cycle with 2 requests in flight → no outputs emitted, addr_o=BASE_ADDR, and the next request is emitted at BASE_ADDR.
